// File: rtl/kpn_fifo_pkg.sv
// ============================================================================
// kpn_fifo_pkg : shared defaults and sizing helper for the kpn_fifo_param FIFO
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package kpn_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than a pointer.
  function automatic int count_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kpn_fifo_mem.sv
// ============================================================================
// kpn_fifo_mem : simple dual-port RAM, synchronous write, asynchronous read
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module kpn_fifo_mem
  import kpn_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/kpn_fifo_param.sv
// ============================================================================
// kpn_fifo_param : parameterised synchronous FIFO with sticky error flags.
//                  Define KPN_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module kpn_fifo_param
  import kpn_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_LVL = (2 ** ADDR_W) - 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic [count_w(ADDR_W)-1:0]  count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = count_w(ADDR_W);

  localparam logic [CNT_W-1:0] c_full_cnt  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_afull_cnt = CNT_W'(AFULL_LVL);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_mem_rdata;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_rd_acc = rd_en && (r_count != '0);
  assign w_wr_acc = wr_en && ((r_count != c_full_cnt) || w_rd_acc);

  kpn_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign count       = r_count;
  assign full        = (r_count == c_full_cnt);
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= c_afull_cnt);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

`ifdef KPN_FIFO_FWFT_EN
  // Head word is always presented; rd_en only pops it.
  assign rd_data  = w_mem_rdata;
  assign rd_valid = (r_count != '0);
`else
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_mem_rdata;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kpn_fifo_param.sv
// ============================================================================
// tb_kpn_fifo_param : table-driven bench for kpn_fifo_param (DEPTH=4, AFULL=3)
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kpn_fifo_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  always #5 clk = ~clk;

  kpn_fifo_param #(
    .DATA_W    (16),
    .ADDR_W    (2),
    .AFULL_LVL (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [15:0] wd;
    logic [2:0]  cnt;
    logic        ov;
    logic        ud;
    logic        rv;
    logic [15:0] rdv;
  } vec_t;

  vec_t tv[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic wr, input logic rd, input logic [15:0] wd,
                     input logic [2:0] cnt, input logic ov, input logic ud,
                     input logic rv, input logic [15:0] rdv);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = cnt;
    v.ov = ov; v.ud = ud; v.rv = rv; v.rdv = rdv;
    tv.push_back(v);
  endtask

  // Drive one cycle; "returned word" is the pre-edge head in FWFT mode and the
  // post-edge registered word in standard mode.
  task automatic apply(input vec_t v, input string tag);
    logic [15:0] pre_d;
    logic        pre_v;
    logic [15:0] ret_d;
    logic        ret_v;
    @(negedge clk);
    reset = v.rst; wr_en = v.wr; rd_en = v.rd; wr_data = v.wd;
    #1;
    pre_d = rd_data;
    pre_v = rd_valid;
    @(posedge clk);
    #1;
`ifdef KPN_FIFO_FWFT_EN
    ret_v = pre_v && v.rd && !v.rst;
    ret_d = pre_d;
`else
    ret_v = rd_valid;
    ret_d = rd_data;
`endif
    chk({tag, ".count"}, 32'(count), 32'(v.cnt));
    chk({tag, ".full"}, 32'(full), 32'(v.cnt == 3'd4));
    chk({tag, ".empty"}, 32'(empty), 32'(v.cnt == 3'd0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(v.cnt >= 3'd3));
    chk({tag, ".overflow"}, 32'(overflow), 32'(v.ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(v.ud));
    chk({tag, ".rvalid"}, 32'(ret_v), 32'(v.rv));
    if (v.rv) chk({tag, ".rdata"}, 32'(ret_d), 32'(v.rdv));
  endtask

  initial begin
    // reset
    add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    // three writes, three ordered reads
    add(0, 1, 0, 16'h0011, 1, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0022, 2, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0033, 3, 0, 0, 0, 16'h0000);
    add(0, 0, 1, 16'h0000, 2, 0, 0, 1, 16'h0011);
    add(0, 0, 1, 16'h0000, 1, 0, 0, 1, 16'h0022);
    add(0, 0, 1, 16'h0000, 0, 0, 0, 1, 16'h0033);
    // fill, overflow write dropped, drain originals
    add(0, 1, 0, 16'h00A1, 1, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h00A2, 2, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h00A3, 3, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h00A4, 4, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'hDEAD, 4, 1, 0, 0, 16'h0000);
    add(0, 0, 1, 16'h0000, 3, 1, 0, 1, 16'h00A1);
    add(0, 0, 1, 16'h0000, 2, 1, 0, 1, 16'h00A2);
    add(0, 0, 1, 16'h0000, 1, 1, 0, 1, 16'h00A3);
    add(0, 0, 1, 16'h0000, 0, 1, 0, 1, 16'h00A4);
    add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    // read+write while full
    add(0, 1, 0, 16'h00B1, 1, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h00B2, 2, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h00B3, 3, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h00B4, 4, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 16'hBEEF, 4, 0, 0, 1, 16'h00B1);
    add(0, 0, 1, 16'h0000, 3, 0, 0, 1, 16'h00B2);
    add(0, 0, 1, 16'h0000, 2, 0, 0, 1, 16'h00B3);
    add(0, 0, 1, 16'h0000, 1, 0, 0, 1, 16'h00B4);
    add(0, 0, 1, 16'h0000, 0, 0, 0, 1, 16'hBEEF);
    // underflow, then read+write on empty
    add(0, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h0000);
    add(0, 1, 1, 16'h0055, 1, 0, 1, 0, 16'h0000);
    add(0, 0, 1, 16'h0000, 0, 0, 1, 1, 16'h0055);
    add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    // 10-word stream, both pointers wrap twice
    add(0, 1, 0, 16'h0100, 1, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0101, 2, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0102, 3, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 7; k++)
      add(0, 1, 1, 16'h0103 + 16'(k), 3, 0, 0, 1, 16'h0100 + 16'(k));
    add(0, 0, 1, 16'h0000, 2, 0, 0, 1, 16'h0107);
    add(0, 0, 1, 16'h0000, 1, 0, 0, 1, 16'h0108);
    add(0, 0, 1, 16'h0000, 0, 0, 0, 1, 16'h0109);
    // reset with count=3 and a sticky flag set
    add(0, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h0000);
    add(0, 1, 0, 16'h0200, 1, 0, 1, 0, 16'h0000);
    add(0, 1, 0, 16'h0201, 2, 0, 1, 0, 16'h0000);
    add(0, 1, 0, 16'h0202, 3, 0, 1, 0, 16'h0000);
    add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h0000);

    for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

    // Reset held with requests asserted; requests must be ignored.
    apply('{rst:1, wr:1, rd:1, wd:16'h1234, cnt:0, ov:0, ud:0, rv:0, rdv:0}, "h.rst0");
    apply('{rst:1, wr:1, rd:1, wd:16'h1234, cnt:0, ov:0, ud:0, rv:0, rdv:0}, "h.rst1");
`ifdef KPN_FIFO_FWFT_EN
    chk("h.rst_rvalid", 32'(rd_valid), 32'd0);
`else
    chk("h.rst_rdata", 32'(rd_data), 32'd0);
`endif
    apply('{rst:0, wr:1, rd:0, wd:16'h0077, cnt:1, ov:0, ud:0, rv:0, rdv:0}, "h.wr");
`ifdef KPN_FIFO_FWFT_EN
    chk("h.fwft_head", 32'(rd_data), 32'h0077);
    chk("h.fwft_valid", 32'(rd_valid), 32'd1);
`endif
    apply('{rst:0, wr:0, rd:1, wd:16'h0000, cnt:0, ov:0, ud:0, rv:1, rdv:16'h0077}, "h.rd");
    apply('{rst:0, wr:0, rd:1, wd:16'h0000, cnt:0, ov:0, ud:1, rv:0, rdv:0}, "h.rd_empty");
`ifndef KPN_FIFO_FWFT_EN
    chk("h.hold_rdata", 32'(rd_data), 32'h0077);
`endif
    chk("h.hold_rvalid", 32'(rd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kpn_fifo_param.md
KPN_FIFO_PARAM -- requirements
Module: kpn_fifo_param

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits (>=1).
REQ-002 Parameter ADDR_W, default 8, pointer width; DEPTH = 2**ADDR_W words (ADDR_W>=1).
REQ-003 Parameter AFULL_LVL, default DEPTH-4, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 One clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_data  in  DATA_W  write word.
REQ-009 rd_en  in  1  read request (standard mode) or pop (FWFT mode).
REQ-010 rd_data  out  DATA_W  read word.
REQ-011 rd_valid  out  1  rd_data holds a valid word.
REQ-012 full, empty, almost_full  out  1 each  occupancy flags.
REQ-013 count  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-014 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-015 Write accepted iff wr_en and (count<DEPTH or read accepted same cycle); word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-016 Read accepted iff rd_en and count>0; rd_ptr increments modulo DEPTH.
REQ-017 count: +1 on write-only, -1 on read-only, unchanged on both or neither; registered, updated same edge.
REQ-018 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL_LVL); all derived from registered count.
REQ-019 Simultaneous read+write when full: both accepted, count stays DEPTH, no overflow.
REQ-020 Simultaneous read+write when empty: write accepted, read refused, underflow set, count becomes 1.
REQ-021 Write refused (full, no read): data dropped, pointers/count unchanged, overflow set on next edge.
REQ-022 Read refused (empty): rd_data holds previous value, rd_valid 0, underflow set on next edge.
REQ-023 overflow/underflow remain 1 until reset.
REQ-024 Pointer wrap from DEPTH-1 to 0 is transparent; no word lost or duplicated across wrap.
REQ-025 Standard mode: rd_data registered from mem[rd_ptr] on accepted read, rd_valid=1 for exactly that following cycle, latency 1 clock.
REQ-026 Data ordering is strict FIFO; a word written at edge N is readable from edge N+1.

Reset
REQ-027 While reset=1 at an edge: wr_ptr, rd_ptr, count=0; empty=1, full=0, almost_full=0; rd_valid=0; rd_data=0; overflow=underflow=0; wr_en/rd_en ignored.
REQ-028 Reset mid-operation discards all stored words; memory contents need not be cleared.

Configuration
REQ-029 Macro KPN_FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-030 With it defined: rd_data = mem[rd_ptr] combinationally, rd_valid = !empty, rd_en pops head; word written at edge N visible on rd_data after edge N when empty beforehand.
REQ-031 Without it: standard mode per REQ-025; all other requirements identical in both modes.

Structure
REQ-032 Package kpn_fifo_pkg holds default DATA_W/ADDR_W constants and the count width function.
REQ-033 Storage is sub-module kpn_fifo_mem: simple dual-port RAM, synchronous write, asynchronous read, DATA_W x DEPTH.
REQ-034 Control (pointers, count, flags) lives in kpn_fifo_param; no latches, non-blocking assignments only.

Verification (bench DATA_W=16, ADDR_W=2, AFULL_LVL=3, both macro settings)
REQ-035 Reset, then write 0x0011,0x0022,0x0033 -> count=3, almost_full=1; three reads return 0x0011,0x0022,0x0033 in order, empty=1 after last.
REQ-036 Write 4 words -> full=1; 5th write 0xDEAD alone -> dropped, overflow=1, reads yield original 4 words.
REQ-037 Full FIFO, rd_en+wr_en with 0xBEEF -> count stays 4, overflow=0, 0xBEEF returned as 4th read thereafter.
REQ-038 Empty FIFO, rd_en only -> rd_valid=0, underflow=1, count=0; rd_en+wr_en 0x0055 -> count=1, next read returns 0x0055.
REQ-039 Stream 10 words 0x0100..0x0109 with interleaved reads crossing pointer wrap twice -> output sequence identical, no flag errors.
REQ-040 Assert reset with count=3 -> next cycle count=0, empty=1, sticky flags cleared, subsequent read returns no stale data (rd_valid=0).
